// File: rtl/io_uart_periph_if.sv
// CPU IO-port bundle: address, write data, strobes and combinational read data.
//   io_addr : byte offset of the IO register
//   io_dout : write data from the CPU
//   io_we   : one-cycle write strobe
//   io_rd   : one-cycle read strobe
//   io_din  : read data to the CPU, combinational from io_addr
interface io_uart_periph_if;
    logic [7:0]  io_addr;
    logic [31:0] io_dout;
    logic        io_we;
    logic        io_rd;
    logic [31:0] io_din;

    modport master (output io_addr, output io_dout, output io_we, output io_rd, input io_din);
    modport slave  (input io_addr, input io_dout, input io_we, input io_rd, output io_din);
endinterface

// File: rtl/io_uart_periph.sv
// IO-bus responder: LED register, free-running cycle counter, and an 8N1 UART
// with a TX byte FIFO and a one-byte RX holding register.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   io   : CPU IO port (slave side); io_din is combinational from io_addr
//   led  : LED register
//   txd  : UART serial out, idle high
//   rxd  : UART serial in, asynchronous to clk
module io_uart_periph #(
    parameter int unsigned CLK_DIV    = 868,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    io_uart_periph_if.slave   io,
    output logic [15:0]       led,
    output logic              txd,
    input  logic              rxd
);

    localparam int unsigned TW = $clog2(CLK_DIV);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    localparam logic [7:0] ADDR_LED    = 8'h00;
    localparam logic [7:0] ADDR_TXDATA = 8'h04;
    localparam logic [7:0] ADDR_TXSTAT = 8'h08;
    localparam logic [7:0] ADDR_RXDATA = 8'h0C;
    localparam logic [7:0] ADDR_RXSTAT = 8'h10;
    localparam logic [7:0] ADDR_CYCLE  = 8'h14;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [TW-1:0] BIT_RELOAD  = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] HALF_RELOAD = TW'(CLK_DIV / 2 - 1);

    // ---------------- address decode ----------------
    logic w_wr_led, w_wr_txdata, w_wr_txstat, w_wr_rxstat, w_wr_cycle, w_rx_pop;
    assign w_wr_led    = io.io_we && (io.io_addr == ADDR_LED);
    assign w_wr_txdata = io.io_we && (io.io_addr == ADDR_TXDATA);
    assign w_wr_txstat = io.io_we && (io.io_addr == ADDR_TXSTAT);
    assign w_wr_rxstat = io.io_we && (io.io_addr == ADDR_RXSTAT);
    assign w_wr_cycle  = io.io_we && (io.io_addr == ADDR_CYCLE);
    assign w_rx_pop    = io.io_rd && (io.io_addr == ADDR_RXDATA);

    // ---------------- LED and cycle counter ----------------
    logic [15:0] r_led;
    logic [31:0] r_cycle;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led   <= '0;
            r_cycle <= '0;
        end else begin
            if (w_wr_led) r_led <= io.io_dout[15:0];
            // A loaded value still counts the cycle it was written in.
            r_cycle <= w_wr_cycle ? io.io_dout + 32'd1 : r_cycle + 32'd1;
        end
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]  r_fifo [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr, r_rd_ptr;
    logic        w_empty, w_full, w_pop, w_push, w_drop;
    logic        r_tx_ovf;
    logic [1:0]  r_tx_state;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = (r_tx_state == S_IDLE) && !w_empty;
    // A simultaneous pop frees a slot, so a push on a full FIFO is still taken.
    assign w_push  = w_wr_txdata && (!w_full || w_pop);
    assign w_drop  = w_wr_txdata && !w_push;

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr[AW-1:0]] <= io.io_dout[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_tx_ovf <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            if (w_drop)           r_tx_ovf <= 1'b1;
            else if (w_wr_txstat) r_tx_ovf <= 1'b0;
        end
    end

    // ---------------- TX serialiser ----------------
    logic [TW-1:0] r_tx_timer, w_tx_timer_nxt;
    logic [2:0]    r_tx_bit, w_tx_bit_nxt;
    logic [7:0]    r_tx_shift, w_tx_shift_nxt;
    logic [1:0]    w_tx_state_nxt;
    logic          r_txd, w_txd_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state <= S_IDLE;
            r_tx_timer <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_txd      <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_timer <= w_tx_timer_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_txd      <= w_txd_nxt;
        end
    end

    // Next-state logic; txd is registered from the next state so it lines up with it.
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_timer_nxt = r_tx_timer;
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_shift_nxt = r_tx_shift;
        w_txd_nxt      = 1'b1;
        case (r_tx_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_tx_state_nxt = S_START;
                    w_tx_timer_nxt = BIT_RELOAD;
                    w_tx_shift_nxt = r_fifo[r_rd_ptr[AW-1:0]];
                end
            end
            S_START: begin
                if (r_tx_timer == '0) begin
                    w_tx_state_nxt = S_DATA;
                    w_tx_timer_nxt = BIT_RELOAD;
                    w_tx_bit_nxt   = 3'd0;
                end else begin
                    w_tx_timer_nxt = r_tx_timer - TW'(1);
                end
            end
            S_DATA: begin
                if (r_tx_timer == '0) begin
                    w_tx_timer_nxt = BIT_RELOAD;
                    w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
                    if (r_tx_bit == 3'd7) w_tx_state_nxt = S_STOP;
                    else                  w_tx_bit_nxt   = r_tx_bit + 3'd1;
                end else begin
                    w_tx_timer_nxt = r_tx_timer - TW'(1);
                end
            end
            default: begin
                if (r_tx_timer == '0) w_tx_state_nxt = S_IDLE;
                else                  w_tx_timer_nxt = r_tx_timer - TW'(1);
            end
        endcase
        case (w_tx_state_nxt)
            S_START: w_txd_nxt = 1'b0;
            S_DATA:  w_txd_nxt = w_tx_shift_nxt[0];
            default: w_txd_nxt = 1'b1;
        endcase
    end

    // ---------------- RX deserialiser ----------------
    logic          r_rx_s1, r_rx_s2, r_rx_prev;
    logic [1:0]    r_rx_state, w_rx_state_nxt;
    logic [TW-1:0] r_rx_timer, w_rx_timer_nxt;
    logic [2:0]    r_rx_bit, w_rx_bit_nxt;
    logic [7:0]    r_rx_shift, w_rx_shift_nxt;
    logic          w_rx_done, w_rx_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= S_IDLE;
            r_rx_timer <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_s1    <= rxd;
            r_rx_s2    <= r_rx_s1;
            r_rx_prev  <= r_rx_s2;
            r_rx_state <= w_rx_state_nxt;
            r_rx_timer <= w_rx_timer_nxt;
            r_rx_bit   <= w_rx_bit_nxt;
            r_rx_shift <= w_rx_shift_nxt;
        end
    end

    // Samples land mid-bit: first at half a bit after the falling edge, then every bit.
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_timer_nxt = r_rx_timer;
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_done      = 1'b0;
        w_rx_bad       = 1'b0;
        case (r_rx_state)
            S_IDLE: begin
                if (r_rx_prev && !r_rx_s2) begin
                    w_rx_state_nxt = S_START;
                    w_rx_timer_nxt = HALF_RELOAD;
                end
            end
            S_START: begin
                if (r_rx_timer == '0) begin
                    w_rx_timer_nxt = BIT_RELOAD;
                    w_rx_bit_nxt   = 3'd0;
                    w_rx_state_nxt = r_rx_s2 ? S_IDLE : S_DATA;
                end else begin
                    w_rx_timer_nxt = r_rx_timer - TW'(1);
                end
            end
            S_DATA: begin
                if (r_rx_timer == '0) begin
                    w_rx_timer_nxt = BIT_RELOAD;
                    w_rx_shift_nxt = {r_rx_s2, r_rx_shift[7:1]};
                    if (r_rx_bit == 3'd7) w_rx_state_nxt = S_STOP;
                    else                  w_rx_bit_nxt   = r_rx_bit + 3'd1;
                end else begin
                    w_rx_timer_nxt = r_rx_timer - TW'(1);
                end
            end
            default: begin
                if (r_rx_timer == '0) begin
                    w_rx_state_nxt = S_IDLE;
                    w_rx_done      = r_rx_s2;
                    w_rx_bad       = !r_rx_s2;
                end else begin
                    w_rx_timer_nxt = r_rx_timer - TW'(1);
                end
            end
        endcase
    end

    // ---------------- RX holding register and flags ----------------
    logic [7:0] r_rx_byte;
    logic       r_rx_valid, r_rx_ovr, r_rx_ferr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_byte  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_ovr   <= 1'b0;
            r_rx_ferr  <= 1'b0;
        end else begin
            if (w_wr_rxstat) begin
                r_rx_ovr  <= 1'b0;
                r_rx_ferr <= 1'b0;
            end
            // A byte completing in the pop cycle wins over the pop.
            if (w_rx_done) begin
                r_rx_byte  <= r_rx_shift;
                r_rx_valid <= 1'b1;
                if (r_rx_valid && !w_rx_pop) r_rx_ovr <= 1'b1;
            end else if (w_rx_pop) begin
                r_rx_valid <= 1'b0;
            end
            if (w_rx_bad) r_rx_ferr <= 1'b1;
        end
    end

    // ---------------- read mux ----------------
    always_comb begin
        io.io_din = '0;
        case (io.io_addr)
            ADDR_LED:    io.io_din = {16'b0, r_led};
            ADDR_TXSTAT: io.io_din = {29'b0, r_tx_ovf, w_full, w_empty && (r_tx_state == S_IDLE)};
            ADDR_RXDATA: io.io_din = {24'b0, r_rx_byte};
            ADDR_RXSTAT: io.io_din = {29'b0, r_rx_ferr, r_rx_ovr, r_rx_valid};
            ADDR_CYCLE:  io.io_din = r_cycle;
            default:     io.io_din = '0;
        endcase
    end

    assign led = r_led;
    assign txd = r_txd;

endmodule

// File: tb/tb_io_uart_periph.sv
// Self-checking bench for io_uart_periph at CLK_DIV=4, FIFO_DEPTH=4.
module tb_io_uart_periph;

    localparam int unsigned CLK_DIV    = 4;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int          FRAME      = 10 * CLK_DIV + 1;

    logic        clk, rst, txd, rxd;
    logic [15:0] led;
    int          n_tests, n_fail, cyc;
    logic        mon_en;
    logic [7:0]  tx_exp_q [$];
    int          start_q  [$];

    io_uart_periph_if bus ();

    io_uart_periph #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus),
        .led (led),
        .txd (txd),
        .rxd (rxd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        we;
        logic [7:0]  waddr;
        logic [31:0] wdata;
        logic [7:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic rdchk(input logic [7:0] a, input logic [31:0] exp, input string name);
        bus.io_addr = a;
        #1;
        chk(name, bus.io_din, exp);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        bus.io_we   = 1'b1;
        bus.io_addr = a;
        bus.io_dout = d;
        @(negedge clk);
        bus.io_we   = 1'b0;
    endtask

    // 8N1 frame on rxd at CLK_DIV cycles per bit, then a short idle.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int j = 0; j < 10; j++) begin
            rxd = bits[j];
            repeat (CLK_DIV) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (CLK_DIV) @(negedge clk);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        bus.io_addr = 8'h08;
        #1;
        while (n < 3000 && !(tx_exp_q.size() == 0 && bus.io_din[0])) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(name, 32'(n < 3000), 32'd1);
    endtask

    // Serial line decoder: reconstructs bytes from txd by mid-bit sampling.
    initial begin
        logic       prev;
        logic [7:0] d;
        int         t0;
        prev = 1'b1;
        d    = '0;
        forever begin
            @(negedge clk);
            if (prev && !txd) begin
                t0 = cyc;
                repeat (CLK_DIV / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CLK_DIV) @(negedge clk);
                    d[i] = txd;
                end
                repeat (CLK_DIV) @(negedge clk);
                if (mon_en) begin
                    start_q.push_back(t0);
                    chk("tx_stop_bit", 32'(txd), 32'd1);
                    if (tx_exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL tx_unexpected: got byte 0x%02h with nothing queued", d);
                    end else begin
                        chk("tx_byte", 32'(d), 32'(tx_exp_q.pop_front()));
                    end
                end
                prev = 1'b1;
            end else begin
                prev = txd;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        rst_vecs [6];
        vec_t        reg_vecs [6];
        logic [15:0] led_m;
        logic [9:0]  frame;
        logic [7:0]  b, m_byte;
        logic        m_valid, m_ovr, m_ferr, good;
        logic [31:0] v;
        int          k, n;

        rst_vecs[0] = '{1'b0, 8'h00, 32'h0, 8'h00, 32'h0};
        rst_vecs[1] = '{1'b0, 8'h00, 32'h0, 8'h08, 32'h1};
        rst_vecs[2] = '{1'b0, 8'h00, 32'h0, 8'h10, 32'h0};
        rst_vecs[3] = '{1'b0, 8'h00, 32'h0, 8'h14, 32'h0};
        rst_vecs[4] = '{1'b0, 8'h00, 32'h0, 8'h0C, 32'h0};
        rst_vecs[5] = '{1'b0, 8'h00, 32'h0, 8'h04, 32'h0};

        reg_vecs[0] = '{1'b1, 8'h00, 32'h1234_ABCD, 8'h00, 32'h0000_ABCD};
        reg_vecs[1] = '{1'b1, 8'h20, 32'hFFFF_FFFF, 8'h00, 32'h0000_ABCD};
        reg_vecs[2] = '{1'b1, 8'h00, 32'hFFFF_5A5A, 8'h00, 32'h0000_5A5A};
        reg_vecs[3] = '{1'b1, 8'h10, 32'hFFFF_FFFF, 8'h10, 32'h0};
        reg_vecs[4] = '{1'b0, 8'h00, 32'h0,         8'h04, 32'h0};
        reg_vecs[5] = '{1'b0, 8'h00, 32'h0,         8'hFC, 32'h0};

        n_tests = 0; n_fail = 0; cyc = 0; mon_en = 1'b0;
        rst = 1'b1; rxd = 1'b1;
        bus.io_addr = '0; bus.io_dout = '0; bus.io_we = 1'b0; bus.io_rd = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        foreach (rst_vecs[i]) rdchk(rst_vecs[i].raddr, rst_vecs[i].exp, $sformatf("rst_vec%0d", i));
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_led", 32'(led), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rdchk(8'h14, 32'd0, "cycle_0");
        rdchk(8'h08, 32'd1, "txstat_rel");
        @(negedge clk); rdchk(8'h14, 32'd1, "cycle_1");
        @(negedge clk); rdchk(8'h14, 32'd2, "cycle_2");

        // Register write/read table
        led_m = '0;
        @(negedge clk);
        foreach (reg_vecs[i]) begin
            if (reg_vecs[i].we) wr(reg_vecs[i].waddr, reg_vecs[i].wdata);
            else                @(negedge clk);
            rdchk(reg_vecs[i].raddr, reg_vecs[i].exp, $sformatf("reg_vec%0d", i));
        end
        led_m = 16'h5A5A;
        chk("led_port", 32'(led), 32'(led_m));

        // Simultaneous write and read returns the pre-edge value
        @(negedge clk);
        bus.io_we = 1'b1; bus.io_rd = 1'b1; bus.io_addr = 8'h00; bus.io_dout = 32'h0000_1111;
        #1 chk("we_rd_old", bus.io_din, 32'(led_m));
        @(negedge clk);
        bus.io_we = 1'b0; bus.io_rd = 1'b0;
        rdchk(8'h00, 32'h1111, "we_rd_new");

        // Single byte 0xA5: exact serial waveform and idle timing
        @(negedge clk);
        wr(8'h04, 32'hA5);
        frame = {1'b1, 8'hA5, 1'b0};
        for (int j = 0; j < 10; j++)
            for (int s = 0; s < CLK_DIV; s++) begin
                @(negedge clk);
                chk($sformatf("a5_bit%0d", j), 32'(txd), 32'(frame[j]));
            end
        rdchk(8'h08, 32'h0, "a5_busy_at_40");
        @(negedge clk);
        rdchk(8'h08, 32'h1, "a5_idle_at_41");

        // Six back-to-back writes into a 4-deep FIFO
        mon_en = 1'b1;
        start_q.delete();
        @(negedge clk);
        for (int i = 1; i <= 6; i++) begin
            bus.io_we = 1'b1; bus.io_addr = 8'h04; bus.io_dout = 32'(i);
            if (i <= 5) tx_exp_q.push_back(8'(i));
            @(negedge clk);
        end
        bus.io_we = 1'b0;
        rdchk(8'h08, 32'h6, "six_full_ovf");
        @(negedge clk);
        wr(8'h08, 32'h0);
        rdchk(8'h08, 32'h2, "six_ovf_cleared");
        wait_drain("six_drain");
        chk("six_frames", 32'(start_q.size()), 32'd5);
        for (int i = 1; i < start_q.size(); i++)
            chk($sformatf("six_gap%0d", i), 32'(start_q[i] - start_q[i-1]), 32'(FRAME));

        // RX directed
        @(negedge clk);
        send_frame(8'h3C, 1'b1);
        rdchk(8'h10, 32'h1, "rx_valid");
        @(negedge clk);
        bus.io_addr = 8'h0C; bus.io_rd = 1'b1;
        #1 chk("rx_data", bus.io_din, 32'h3C);
        @(negedge clk);
        bus.io_rd = 1'b0;
        rdchk(8'h10, 32'h0, "rx_popped");
        @(negedge clk);
        send_frame(8'h81, 1'b1);
        send_frame(8'h7E, 1'b1);
        rdchk(8'h10, 32'h3, "rx_ovr");
        rdchk(8'h0C, 32'h7E, "rx_ovr_data");
        @(negedge clk);
        wr(8'h10, 32'h0);
        bus.io_addr = 8'h0C; bus.io_rd = 1'b1;
        @(negedge clk);
        bus.io_rd = 1'b0;
        rdchk(8'h10, 32'h0, "rx_cleared");
        @(negedge clk);
        send_frame(8'h55, 1'b0);
        rdchk(8'h10, 32'h4, "rx_ferr");
        @(negedge clk);
        wr(8'h10, 32'h0);
        rdchk(8'h10, 32'h0, "rx_ferr_clr");
        @(negedge clk);
        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        repeat (20) @(negedge clk);
        rdchk(8'h10, 32'h0, "rx_glitch");

        // RX randomized against a flag/byte model
        m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_byte = '0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            b    = 8'($urandom);
            good = ($urandom_range(0, 4) != 0);
            send_frame(b, good);
            if (good) begin
                if (m_valid) m_ovr = 1'b1;
                m_byte  = b;
                m_valid = 1'b1;
            end else begin
                m_ferr = 1'b1;
            end
            rdchk(8'h10, {29'b0, m_ferr, m_ovr, m_valid}, "rnd_rxstat");
            if (m_valid) rdchk(8'h0C, 32'(m_byte), "rnd_rxdata");
            k = int'($urandom_range(0, 3));
            @(negedge clk);
            if (k == 0) begin
                bus.io_addr = 8'h0C; bus.io_rd = 1'b1;
                @(negedge clk);
                bus.io_rd = 1'b0;
                m_valid = 1'b0;
            end else if (k == 1) begin
                wr(8'h10, 32'h0);
                m_ovr = 1'b0; m_ferr = 1'b0;
            end
        end

        // TX randomized: bytes out must match bytes in, in order
        start_q.delete();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.io_addr = 8'h08;
            #1;
            n = 0;
            while (bus.io_din[1] && n < 2000) begin
                @(negedge clk);
                #1;
                n++;
            end
            b = 8'($urandom);
            tx_exp_q.push_back(b);
            @(negedge clk);
            wr(8'h04, 32'(b));
            repeat ($urandom_range(0, 30)) @(negedge clk);
        end
        wait_drain("rnd_tx_drain");
        rdchk(8'h08, 32'h1, "rnd_tx_no_ovf");

        // Cycle counter load and wrap
        @(negedge clk);
        wr(8'h14, 32'hFFFF_FFFE);
        rdchk(8'h14, 32'hFFFF_FFFF, "cycle_load");
        @(negedge clk);
        rdchk(8'h14, 32'h0, "cycle_wrap");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            v = $urandom;
            k = int'($urandom_range(0, 20));
            wr(8'h14, v);
            repeat (k) @(negedge clk);
            rdchk(8'h14, v + 32'd1 + 32'(k), "cycle_rnd");
        end

        // Reset in the middle of a TX frame
        mon_en = 1'b0;
        @(negedge clk);
        wr(8'h04, 32'h55);
        wr(8'h04, 32'hAA);
        @(negedge clk);
        chk("pre_rst_txd", 32'(txd), 32'd0);
        #1 rst = 1'b1;
        #1 chk("rst_txd_async", 32'(txd), 32'd1);
        rdchk(8'h08, 32'h1, "rst_txstat");
        @(negedge clk);
        rst = 1'b0;
        rdchk(8'h00, 32'h0, "rst_led_clr");
        rdchk(8'h14, 32'h0, "rst_cycle_clr");
        repeat (60) @(negedge clk);
        chk("rst_txd_idle", 32'(txd), 32'd1);
        rdchk(8'h08, 32'h1, "rst_fifo_empty");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
